// File: rtl/issue_cdb_scheduler_pkg.sv
// Shared types for the issue/CDB scheduler: queue identifiers, fixed unit latencies and
// the CDB reservation slot layout.
package issue_cdb_scheduler_pkg;

    typedef enum logic [1:0] {
        INT_FIFO  = 2'd0,
        LDST_FIFO = 2'd1,
        MULT_FIFO = 2'd2,
        DIV_FIFO  = 2'd3
    } fifo_data_type;

    localparam int unsigned INT_LAT  = 1;
    localparam int unsigned LDST_LAT = 1;

    typedef struct packed {
        logic          valid;
        fifo_data_type owner;
    } cdb_rsv_slot;

endpackage

// File: rtl/issue_rr_arb2.sv
// Two-way round-robin arbiter for the INT/LD-ST shared CDB slot; the pointer only
// advances when both requesters contend, and flush returns it to INT priority.
module issue_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_ldst_q, rr_ldst_d;

    always_comb begin
        gnt       = req;
        rr_ldst_d = rr_ldst_q;
        if (req == 2'b11) begin
            gnt       = rr_ldst_q ? 2'b10 : 2'b01;
            rr_ldst_d = ~rr_ldst_q;
        end
        if (flush) begin
            rr_ldst_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ldst_q <= 1'b0;
        end else begin
            rr_ldst_q <= rr_ldst_d;
        end
    end

endmodule

// File: rtl/issue_cdb_scheduler.sv
// Issue-stage scheduler granting INT/LD-ST/MULT/DIV so no two results share a CDB cycle.
// Define DIV_UNIT_EN to include the non-pipelined divider path.
module issue_cdb_scheduler
    import issue_cdb_scheduler_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       int_issue_rdy,
    input  logic       ldst_issue_rdy,
    input  logic       mult_issue_rdy,
    input  logic       div_issue_rdy,
    output logic       int_issue_en,
    output logic       ldst_issue_en,
    output logic       mult_issue_en,
    output logic       div_issue_en,
    output logic [1:0] cdb_owner,
    output logic       cdb_owner_valid
);

`ifdef DIV_UNIT_EN
    localparam int TopIdx = int'(DIV_LAT);
`else
    localparam int TopIdx = int'(MULT_LAT);
    localparam int unsigned UnusedDivLat = DIV_LAT;
`endif

    // rsv_q[k] is the CDB slot broadcasting k cycles from now.
    cdb_rsv_slot [TopIdx:0] rsv_q, rsv_d;
    logic                   can_issue;
    logic [1:0]             arb_req, arb_gnt;

    // Grants are also held off during reset so every output is quiet while rst_n is low.
    assign can_issue = rst_n & ~flush;

    assign arb_req[0] = can_issue & int_issue_rdy  & ~rsv_q[INT_LAT].valid;
    assign arb_req[1] = can_issue & ldst_issue_rdy & ~rsv_q[LDST_LAT].valid;

    issue_rr_arb2 u_rr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    assign int_issue_en  = arb_gnt[0];
    assign ldst_issue_en = arb_gnt[1];
    assign mult_issue_en = can_issue & mult_issue_rdy & ~rsv_q[MULT_LAT].valid;

`ifdef DIV_UNIT_EN
    localparam int DivCntW = $clog2(DIV_LAT);
    logic [DivCntW-1:0] div_cnt_q, div_cnt_d;

    assign div_issue_en = can_issue & div_issue_rdy & ~rsv_q[DIV_LAT].valid &
                          (div_cnt_q == '0);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (flush) begin
            div_cnt_d = '0;
        end else if (div_issue_en) begin
            div_cnt_d = DivCntW'(DIV_LAT - 1);
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end
`else
    logic unused_div_rdy;
    assign unused_div_rdy = div_issue_rdy;
    assign div_issue_en   = 1'b0;
`endif

    always_comb begin
        rsv_d = '0;
        for (int k = 0; k < TopIdx; k++) begin
            rsv_d[k] = rsv_q[k+1];
        end
        if (int_issue_en) begin
            rsv_d[INT_LAT-1] = '{valid: 1'b1, owner: INT_FIFO};
        end
        if (ldst_issue_en) begin
            rsv_d[LDST_LAT-1] = '{valid: 1'b1, owner: LDST_FIFO};
        end
        if (mult_issue_en) begin
            rsv_d[MULT_LAT-1] = '{valid: 1'b1, owner: MULT_FIFO};
        end
`ifdef DIV_UNIT_EN
        if (div_issue_en) begin
            rsv_d[DIV_LAT-1] = '{valid: 1'b1, owner: DIV_FIFO};
        end
`endif
        if (flush) begin
            for (int k = 0; k <= TopIdx; k++) begin
                rsv_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsv_q <= '0;
        end else begin
            rsv_q <= rsv_d;
        end
    end

    assign cdb_owner       = rsv_q[0].owner;
    assign cdb_owner_valid = rsv_q[0].valid;

endmodule

// File: tb/tb_issue_cdb_scheduler.sv
// Scoreboard bench for issue_cdb_scheduler: a calendar model keyed by absolute cycle
// predicts grants and CDB owners; DIV expectations follow DIV_UNIT_EN.
module tb_issue_cdb_scheduler;
    import issue_cdb_scheduler_pkg::*;

    localparam int MultLat = 4;
    localparam int DivLat  = 8;
`ifdef DIV_UNIT_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, flush;
    logic       int_issue_rdy, ldst_issue_rdy, mult_issue_rdy, div_issue_rdy;
    logic       int_issue_en, ldst_issue_en, mult_issue_en, div_issue_en;
    logic [1:0] cdb_owner;
    logic       cdb_owner_valid;

    always #5 clk = ~clk;

    issue_cdb_scheduler #(
        .MULT_LAT (MultLat),
        .DIV_LAT  (DivLat)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .int_issue_rdy   (int_issue_rdy),
        .ldst_issue_rdy  (ldst_issue_rdy),
        .mult_issue_rdy  (mult_issue_rdy),
        .div_issue_rdy   (div_issue_rdy),
        .int_issue_en    (int_issue_en),
        .ldst_issue_en   (ldst_issue_en),
        .mult_issue_en   (mult_issue_en),
        .div_issue_en    (div_issue_en),
        .cdb_owner       (cdb_owner),
        .cdb_owner_valid (cdb_owner_valid)
    );

    typedef struct {
        logic [3:0] gnt;  // {div, mult, ldst, int}
        logic       cv;
        logic [1:0] co;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: absolute cycle -> owner of the result broadcasting then.
    int cal[int];
    bit rr;
    int div_free_at;
    int cyc;

    function automatic void check(string name, int cycle, int act, int req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cycle, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("grants", mon_e.cyc,
                  int'({div_issue_en, mult_issue_en, ldst_issue_en, int_issue_en}),
                  int'(mon_e.gnt));
            check("cdb_valid", mon_e.cyc, int'(cdb_owner_valid), int'(mon_e.cv));
            if (mon_e.cv) begin
                check("cdb_owner", mon_e.cyc, int'(cdb_owner), int'(mon_e.co));
            end
        end
    end

    task automatic step(input bit ir, input bit lr, input bit mr, input bit dr,
                        input bit fl, input bit rs);
        exp_t e;
        bit   gi, gl, gm, gd, ei, el;
        @(posedge clk);
        #1;
        rst_n          = !rs;
        flush          = fl;
        int_issue_rdy  = ir;
        ldst_issue_rdy = lr;
        mult_issue_rdy = mr;
        div_issue_rdy  = dr;
        if (rs) begin
            cal.delete();
            rr          = 1'b0;
            div_free_at = 0;
        end
        e.cyc = cyc;
        e.cv  = cal.exists(cyc);
        e.co  = e.cv ? 2'(cal[cyc]) : 2'd0;
        gi = 0; gl = 0; gm = 0; gd = 0;
        if (!rs && !fl) begin
            ei = ir && !cal.exists(cyc + 1);
            el = lr && !cal.exists(cyc + 1);
            if (ei && el) begin
                if (rr) gl = 1; else gi = 1;
                rr = !rr;
            end else begin
                gi = ei;
                gl = el;
            end
            gm = mr && !cal.exists(cyc + MultLat);
            gd = DivEn && dr && !cal.exists(cyc + DivLat) && (cyc >= div_free_at);
            if (gi) cal[cyc + 1] = int'(INT_FIFO);
            if (gl) cal[cyc + 1] = int'(LDST_FIFO);
            if (gm) cal[cyc + MultLat] = int'(MULT_FIFO);
            if (gd) begin
                cal[cyc + DivLat] = int'(DIV_FIFO);
                div_free_at       = cyc + DivLat;
            end
        end
        if (fl) begin
            cal.delete();
            rr          = 1'b0;
            div_free_at = 0;
        end
        e.gnt = {gd, gm, gl, gi};
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        int_issue_rdy  = 1'b0;
        ldst_issue_rdy = 1'b0;
        mult_issue_rdy = 1'b0;
        div_issue_rdy  = 1'b0;
        rr             = 1'b0;
        div_free_at    = 0;
        cyc            = 0;
        #12;
        check("reset_grants", -1,
              int'({div_issue_en, mult_issue_en, ldst_issue_en, int_issue_en}), 0);
        check("reset_cdb_valid", -1, int'(cdb_owner_valid), 0);
        check("reset_cdb_owner", -1, int'(cdb_owner), int'(INT_FIFO));

        // Back-to-back INT.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
        idle(2);
        // INT/LD-ST contention alternates.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
        idle(2);
        // MULT blocks INT MULT_LAT-1 cycles later.
        step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
        idle(2);
        // DIV throughput.
        for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 0, 0);
        idle(9);
        // Flush kills an in-flight MULT.
        step(0, 0, 1, 0, 0, 0);
        step(1, 1, 1, 1, 1, 0);
        idle(6);
        // Reset in the middle of a DIV.
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        step(1, 1, 1, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        idle(DivLat + 1);

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 2) == 0),
                 bit'($urandom_range(0, 23) == 0), bit'($urandom_range(0, 79) == 0));
        end
        idle(DivLat + 2);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
